// File: rtl/uart_rx_frame.sv
// UART receive framer: times the bit cell from a start-edge strobe, samples mid-cell, emits byte or error strobes.
// Optional even-parity bit compiled in with `define UART_RX_PARITY_EN.
module uart_rx_frame #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_pin_in,
  input  logic       h2l_sig,
  output logic [7:0] rx_data,
  output logic       rx_done_sig,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int CPB  = CLK_HZ / BAUD;
  localparam int HALF = CPB / 2;
  localparam int CW   = (CPB > 1) ? $clog2(CPB) : 1;

  localparam logic [CW-1:0] CNT_HALF = CW'(HALF);
  localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd4;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;

  function automatic logic even_par_err(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction
`endif

  logic          rx_sync_p0;
  logic          rx_s;
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          cell_end;
`ifdef UART_RX_PARITY_EN
  logic          par_bit;
  logic          par_err_q;
`endif

  // stage p0/p1: two-flop synchronizer on the raw pin, idle-high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync_p0 <= 1'b1;
      rx_s       <= 1'b1;
    end else begin
      rx_sync_p0 <= rx_pin_in;
      rx_s       <= rx_sync_p0;
    end
  end

  assign cell_end = (cnt == CNT_LAST);

  // framing FSM; strobes default low so each is a single registered pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= 3'd0;
      shreg       <= 8'h00;
      rx_data     <= 8'h00;
      rx_done_sig <= 1'b0;
      frame_err   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit     <= 1'b0;
      par_err_q   <= 1'b0;
`endif
    end else begin
      rx_done_sig <= 1'b0;
      frame_err   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          cnt <= '0;
          if (h2l_sig) state <= START;
        end
        START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
            end else begin
              state   <= DATA;
              bit_idx <= 3'd0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cell_end) begin
            cnt            <= '0;
            shreg[bit_idx] <= rx_s;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cell_end) begin
            cnt     <= '0;
            par_bit <= rx_s;
            state   <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (cell_end) begin
            cnt   <= '0;
            state <= IDLE;
            // a low stop bit outranks a parity mismatch
            if (!rx_s) begin
              frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (even_par_err(shreg, par_bit)) begin
              par_err_q <= 1'b1;
`endif
            end else begin
              rx_data     <= shreg;
              rx_done_sig <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

`ifdef UART_RX_PARITY_EN
  assign parity_err = par_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frame.sv
// Scoreboard bench for uart_rx_frame: a line driver feeds an edge detector and the DUT; a monitor checks every strobe.
module tb_uart_rx_frame;

  localparam int CPB  = 16;
  localparam int HALF = 8;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 10;
`else
  localparam int NB = 9;
`endif
  // pin fall -> h2l is 2 cycles, h2l -> strobe is 2 + HALF + NB*CPB
  localparam int LAT = 4 + HALF + NB * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pin = 1'b1;
  logic       d0 = 1'b1, d1 = 1'b1, h2l = 1'b0;
  logic [7:0] rx_data;
  logic       rx_done_sig, frame_err, parity_err, busy;

  uart_rx_frame #(.CLK_HZ(16), .BAUD(1)) dut (
    .clk(clk), .rst_n(rst_n), .rx_pin_in(pin), .h2l_sig(h2l),
    .rx_data(rx_data), .rx_done_sig(rx_done_sig), .frame_err(frame_err),
    .parity_err(parity_err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    d0  <= pin;
    d1  <= d0;
    h2l <= d1 & ~d0;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         kind;   // 0 done, 1 frame error, 2 parity error
    logic [7:0] data;
    int         at;
  } exp_t;

  exp_t       sbq[$];
  int         total = 0;
  int         bad = 0;
  logic [7:0] last_good = 8'h00;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  logic [2:0] strobe;
  exp_t       em;
  int         act_kind;
  always @(negedge clk) begin
    if (rst_n) begin
      strobe = {rx_done_sig, frame_err, parity_err};
      if (strobe != 3'b000) begin
        check("strobe_onehot", $countones(strobe), 1);
        check("busy_at_strobe", busy, 0);
        if (sbq.size() == 0) begin
          check("unexpected_strobe", strobe, 0);
        end else begin
          em = sbq.pop_front();
          act_kind = rx_done_sig ? 0 : (frame_err ? 1 : 2);
          check("strobe_kind", act_kind, em.kind);
          check("rx_data", rx_data, em.data);
          check("strobe_cycle", cyc, em.at);
        end
      end else if (sbq.size() > 0 && cyc > sbq[0].at) begin
        check("missed_strobe_cycle", cyc, sbq[0].at);
        void'(sbq.pop_front());
      end
    end
  end

  task automatic idle(input int g);
    pin = 1'b1;
    repeat (g) begin @(posedge clk); #1; end
  endtask

  // drive one frame; the expected outcome follows from the line contents alone
  task automatic send(input logic [7:0] b, input logic stop_bit, input logic par_flip);
    logic [11:0] bits;
    int          n;
    exp_t        e;
    bits = '1;
    bits[0] = 1'b0;
    bits[8:1] = b;
`ifdef UART_RX_PARITY_EN
    bits[9]  = (^b) ^ par_flip;
    bits[10] = stop_bit;
    n = 11;
`else
    bits[9] = stop_bit;
    n = 10;
`endif
    e.at = cyc + LAT;
    if (!stop_bit) begin
      e.kind = 1; e.data = last_good;
`ifdef UART_RX_PARITY_EN
    end else if (par_flip) begin
      e.kind = 2; e.data = last_good;
`endif
    end else begin
      e.kind = 0; e.data = b; last_good = b;
    end
    sbq.push_back(e);
    for (int i = 0; i < n; i++) begin
      pin = bits[i];
      repeat (CPB) begin @(posedge clk); #1; end
    end
  endtask

  task automatic glitch();
    int cnt;
    cnt = 0;
    pin = 1'b0;
    for (int i = 1; i <= 34; i++) begin
      @(posedge clk); #1;
      if (i == 4) pin = 1'b1;
      if (busy) cnt++;
    end
    check("glitch_busy_cycles", cnt, HALF + 1);
  endtask

  initial begin
    logic       prev_stop;
    logic [7:0] b;
    logic       s, f;

    repeat (3) @(posedge clk);
    #1;
    check("reset_rx_data", rx_data, 0);
    check("reset_done", rx_done_sig, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_parity_err", parity_err, 0);
    check("reset_busy", busy, 0);
    rst_n = 1'b1;
    idle(5);

    send(8'hA5, 1'b1, 1'b0);
    idle(3);
    glitch();
    check("rx_data_after_glitch", rx_data, 8'hA5);
    send(8'h5A, 1'b0, 1'b0);
    idle(4);
    send(8'h00, 1'b1, 1'b0);
    send(8'hFF, 1'b1, 1'b0);
    idle(3);

    // abort a frame in its data bits with reset
    pin = 1'b0;
    repeat (3 * CPB) begin @(posedge clk); #1; end
    check("busy_mid_frame", busy, 1);
    rst_n = 1'b0;
    pin = 1'b1;
    #1;
    check("midrst_rx_data", rx_data, 0);
    check("midrst_done", rx_done_sig, 0);
    check("midrst_frame_err", frame_err, 0);
    check("midrst_parity_err", parity_err, 0);
    check("midrst_busy", busy, 0);
    last_good = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(20);
    send(8'h3C, 1'b1, 1'b0);
    idle(3);

`ifdef UART_RX_PARITY_EN
    send(8'h07, 1'b1, 1'b1);
    idle(3);
    send(8'h07, 1'b1, 1'b0);
    idle(3);
`endif

    prev_stop = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        idle(2);
        glitch();
        prev_stop = 1'b1;
      end
      idle(prev_stop ? $urandom_range(0, 12) : $urandom_range(2, 12));
      b = 8'($urandom);
      s = ($urandom_range(0, 5) != 0);
`ifdef UART_RX_PARITY_EN
      f = ($urandom_range(0, 4) == 0);
`else
      f = 1'b0;
`endif
      send(b, s, f);
      prev_stop = s;
    end

    idle(200);
    check("queue_drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
